drive_select_multi: RTL and testbench
=====================================

Name: drive_select_multi

Overview:
Parametrised successor to the single-drive select/spin-up emulation. It emulates N 2315 drive positions, each with its own spin-up timer driving the emulated 90-second relay, a spin-down timer driving the emulated cartridge-unlock indication, and a registered one-hot Selected decode from the CPU unit address. It sits between the microSD cartridge loader (Cart_Ready) and the BUS interface logic. Positions flagged as real drives are left entirely to the physical hardware.

Parameters:
NUM_DRIVES, 2, number of emulated drive positions (1..4)
SEL_WIDTH, 2, width of the unit-address input
USEC_PER_SEC, 1000000, clkenbl_1usec pulses per emulated second (shrink for simulation)
SPINUP_SEC, 90, seconds from start request to relay assertion
SPINDOWN_SEC, 15, seconds from stop to unlock assertion
SEC_W, 7, seconds-counter width (must hold max(SPINUP_SEC, SPINDOWN_SEC))

Ports:
clock  in  1  system clock
reset_L  in  1  synchronous active-low reset
clkenbl_1usec  in  1  one-cycle 1 µs enable from the timing generator
Cart_Ready  in  NUM_DRIVES  cartridge image loaded, per drive
BUS_FILE_READY_DRIVE_L  in  NUM_DRIVES  active-low start/file-ready request, per drive
real_drive  in  NUM_DRIVES  1 = physical drive present; emulation is inert for that position
drive_sel  in  SEL_WIDTH  CPU unit address
drive_sel_valid  in  1  drive_sel is valid
BUS_90SEC_RELAY_EMUL_L  out  NUM_DRIVES  active-low relay, per drive
BUS_UNLOCKED_EMUL_L  out  NUM_DRIVES  active-low unlocked, per drive
Selected  out  NUM_DRIVES  one-hot selected-and-ready
drive_state  out  2*NUM_DRIVES  per-drive FSM state, for the status display

Behaviour:
- Reset (reset_L=0 at a clock edge):
  - All drive FSMs go to IDLE.
  - All counters clear.
  - Relay outputs = all 1, unlocked outputs = all 1, Selected = 0, drive_state = 0.
- All outputs are registered.
- Per-drive start condition: start[i] = Cart_Ready[i] & ~BUS_FILE_READY_DRIVE_L[i] & ~real_drive[i].
- Per-drive timing counters:
  - usec counter counts clkenbl_1usec pulses. At USEC_PER_SEC-1 plus an enable it wraps to 0 and issues sec_tick.
  - sec counter increments on sec_tick.
  - Both counters clear on every FSM state change.
- Drive FSM states: IDLE=0, SPINUP=1, READY=2, SPINDOWN=3.
  - IDLE: start -> SPINUP.
  - SPINUP:
    - ~start -> SPINDOWN.
    - Otherwise, sec_tick with sec==SPINUP_SEC-1 -> READY.
    - If both occur in the same cycle, SPINDOWN wins.
  - READY: ~start -> SPINDOWN.
  - SPINDOWN:
    - start -> SPINUP. Counting restarts from zero, so a full spin-up period is required.
    - Otherwise, sec_tick with sec==SPINDOWN_SEC-1 -> IDLE.
- Outputs, updated on the clock edge after the state change:
  - Relay[i] = 0 only in READY.
  - Unlocked[i] = 0 only in IDLE with real_drive[i]=0.
- Relay timing: the relay asserts on the cycle after the (SPINUP_SEC*USEC_PER_SEC)-th enable following SPINUP entry.
- real_drive[i]=1 at any time:
  - Forces IDLE on the next edge and clears the counters.
  - Relay[i], Unlocked[i] and Selected[i] are held at their inactive values while it stays 1.
- Selected[i] is registered, with 1-cycle latency, and is 1 when all of the following hold:
  - drive_sel_valid
  - drive_sel==i
  - state[i]==READY
  - ~real_drive[i]
- A drive_sel value >= NUM_DRIVES gives Selected=0. Selected is never multi-hot.
- Cart_Ready dropping in READY (cartridge ejected or reloading): the relay deasserts on the next cycle and spin-down begins.
- The FSMs are fully independent; simultaneous events on different drives do not interact.

Decomposition:
- Package drive_select_pkg holds:
  - the 2-bit state typedef with the IDLE/SPINUP/READY/SPINDOWN encodings;
  - the default timing constants (90 s, 15 s, 1 000 000 µs/s).
- Sub-module drive_channel holds one FSM, the usec and sec counters, and the registered relay/unlocked outputs. It is instantiated NUM_DRIVES times in a generate loop.
- The top level holds the real_drive gating and the Selected decode.

Test Plan:
All scenarios use NUM_DRIVES=2, USEC_PER_SEC=10, SPINUP_SEC=3, SPINDOWN_SEC=2, and clkenbl_1usec every 40 clocks.
1. Reset: hold reset_L=0 for 3 clocks -> relay=2'b11, unlocked=2'b11, Selected=2'b00. One cycle after release, unlocked=2'b00.
2. Spin-up: Cart_Ready=2'b01, FILE_READY_L=2'b10 -> drive0 unlocked goes high next cycle, relay[0]=0 exactly one cycle after the 30th enable. Drive1 stays IDLE with unlocked[1]=0.
3. Select: drive0 READY, drive_sel=0, valid=1 -> Selected=2'b01 next cycle. drive_sel=1 -> 2'b00. drive_sel=3 -> 2'b00. valid=0 -> 2'b00.
4. Eject: drop Cart_Ready[0] in READY -> relay[0]=1 next cycle, unlocked[0]=0 one cycle after the 20th enable.
5. Restart: reassert start[0] after 12 enables into SPINDOWN -> SPINUP entered, relay[0]=0 only after a further 30 enables.
6. Real drive: set real_drive[1]=1 after 15 enables into drive1 SPINUP -> drive_state[1]=IDLE, relay[1]=1, unlocked[1]=1, Selected[1]=0 for any drive_sel.

Source files
------------

// File: rtl/drive_select_pkg.sv
// Shared types and default timing for the emulated 2315 drive select / spin-up logic.
package drive_select_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SPINUP   = 2'd1,
    ST_READY    = 2'd2,
    ST_SPINDOWN = 2'd3
  } drive_state_e;

  localparam int DEF_USEC_PER_SEC = 1000000;
  localparam int DEF_SPINUP_SEC   = 90;
  localparam int DEF_SPINDOWN_SEC = 15;

endpackage

// File: rtl/drive_channel.sv
// One emulated drive position: spin-up/spin-down FSM, usec/sec timers, registered relay/unlock.
//
// state       | meaning
// IDLE        | cartridge unlocked, waiting for start request
// SPINUP      | timing the emulated 90 s relay delay
// READY       | relay asserted, drive usable
// SPINDOWN    | timing the unlock delay after a stop
module drive_channel
  import drive_select_pkg::*;
#(
  parameter int USEC_PER_SEC = DEF_USEC_PER_SEC,
  parameter int SPINUP_SEC   = DEF_SPINUP_SEC,
  parameter int SPINDOWN_SEC = DEF_SPINDOWN_SEC,
  parameter int SEC_W        = 7
) (
  input  logic         clock,
  input  logic         reset_L,
  input  logic         clkenbl_1usec,
  input  logic         start,
  input  logic         force_idle,
  output logic         relay_l,
  output logic         unlocked_l,
  output drive_state_e state
);

  localparam int USEC_W = (USEC_PER_SEC > 1) ? $clog2(USEC_PER_SEC) : 1;
  localparam logic [USEC_W-1:0] USEC_LAST = USEC_W'(USEC_PER_SEC - 1);
  localparam logic [SEC_W-1:0]  UP_LAST   = SEC_W'(SPINUP_SEC - 1);
  localparam logic [SEC_W-1:0]  DOWN_LAST = SEC_W'(SPINDOWN_SEC - 1);

  logic [USEC_W-1:0] usec_cnt;
  logic [SEC_W-1:0]  sec_cnt;
  logic              sec_tick;

  assign sec_tick = clkenbl_1usec && (usec_cnt == USEC_LAST);

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state      <= ST_IDLE;
      usec_cnt   <= '0;
      sec_cnt    <= '0;
      relay_l    <= 1'b1;
      unlocked_l <= 1'b1;
    end else begin
      // Outputs follow the state register, so they lag a state change by one edge.
      relay_l    <= (state != ST_READY) || force_idle;
      unlocked_l <= (state != ST_IDLE) || force_idle;

      if (clkenbl_1usec) usec_cnt <= sec_tick ? '0 : usec_cnt + 1'b1;
      if (sec_tick)      sec_cnt  <= sec_cnt + 1'b1;

      if (force_idle) begin
        state    <= ST_IDLE;
        usec_cnt <= '0;
        sec_cnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            state    <= ST_SPINUP;
            usec_cnt <= '0;
            sec_cnt  <= '0;
          end
          ST_SPINUP: if (!start) begin
            state    <= ST_SPINDOWN;
            usec_cnt <= '0;
            sec_cnt  <= '0;
          end else if (sec_tick && sec_cnt == UP_LAST) begin
            state    <= ST_READY;
            usec_cnt <= '0;
            sec_cnt  <= '0;
          end
          ST_READY: if (!start) begin
            state    <= ST_SPINDOWN;
            usec_cnt <= '0;
            sec_cnt  <= '0;
          end
          ST_SPINDOWN: if (start) begin
            state    <= ST_SPINUP;
            usec_cnt <= '0;
            sec_cnt  <= '0;
          end else if (sec_tick && sec_cnt == DOWN_LAST) begin
            state    <= ST_IDLE;
            usec_cnt <= '0;
            sec_cnt  <= '0;
          end
          default: begin
            state    <= ST_IDLE;
            usec_cnt <= '0;
            sec_cnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/drive_select_multi.sv
// N-position drive select/spin-up emulation; physical drives leave their position inert.
module drive_select_multi
  import drive_select_pkg::*;
#(
  parameter int NUM_DRIVES   = 2,
  parameter int SEL_WIDTH    = 2,
  parameter int USEC_PER_SEC = DEF_USEC_PER_SEC,
  parameter int SPINUP_SEC   = DEF_SPINUP_SEC,
  parameter int SPINDOWN_SEC = DEF_SPINDOWN_SEC,
  parameter int SEC_W        = 7
) (
  input  logic                    clock,
  input  logic                    reset_L,
  input  logic                    clkenbl_1usec,
  input  logic [NUM_DRIVES-1:0]   Cart_Ready,
  input  logic [NUM_DRIVES-1:0]   BUS_FILE_READY_DRIVE_L,
  input  logic [NUM_DRIVES-1:0]   real_drive,
  input  logic [SEL_WIDTH-1:0]    drive_sel,
  input  logic                    drive_sel_valid,
  output logic [NUM_DRIVES-1:0]   BUS_90SEC_RELAY_EMUL_L,
  output logic [NUM_DRIVES-1:0]   BUS_UNLOCKED_EMUL_L,
  output logic [NUM_DRIVES-1:0]   Selected,
  output logic [2*NUM_DRIVES-1:0] drive_state
);

  logic [NUM_DRIVES-1:0] sel_next;

  for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_drive
    logic         start;
    drive_state_e st;

    assign start = Cart_Ready[i] & ~BUS_FILE_READY_DRIVE_L[i] & ~real_drive[i];

    drive_channel #(
      .USEC_PER_SEC (USEC_PER_SEC),
      .SPINUP_SEC   (SPINUP_SEC),
      .SPINDOWN_SEC (SPINDOWN_SEC),
      .SEC_W        (SEC_W)
    ) u_chan (
      .clock         (clock),
      .reset_L       (reset_L),
      .clkenbl_1usec (clkenbl_1usec),
      .start         (start),
      .force_idle    (real_drive[i]),
      .relay_l       (BUS_90SEC_RELAY_EMUL_L[i]),
      .unlocked_l    (BUS_UNLOCKED_EMUL_L[i]),
      .state         (st)
    );

    assign drive_state[2*i +: 2] = st;
    // An exact address match per position keeps Selected one-hot by construction.
    assign sel_next[i] = drive_sel_valid && (drive_sel == SEL_WIDTH'(i)) &&
                         (st == ST_READY) && !real_drive[i];
  end

  always_ff @(posedge clock) begin
    if (!reset_L) Selected <= '0;
    else          Selected <= sel_next;
  end

endmodule

// File: tb/tb_drive_select_multi.sv
// Directed plus randomized bench for drive_select_multi against an enable-counting reference model.
module tb_drive_select_multi;

  localparam int ND   = 2;
  localparam int SW   = 2;
  localparam int USEC = 10;
  localparam int UP   = 3;
  localparam int DOWN = 2;
  localparam int P_IDLE = 0, P_SPINUP = 1, P_READY = 2, P_SPINDOWN = 3;

  logic            clock = 1'b0;
  logic            reset_L = 1'b0;
  logic            clkenbl_1usec = 1'b0;
  logic [ND-1:0]   Cart_Ready = '0;
  logic [ND-1:0]   BUS_FILE_READY_DRIVE_L = '1;
  logic [ND-1:0]   real_drive = '0;
  logic [SW-1:0]   drive_sel = '0;
  logic            drive_sel_valid = 1'b0;
  logic [ND-1:0]   BUS_90SEC_RELAY_EMUL_L;
  logic [ND-1:0]   BUS_UNLOCKED_EMUL_L;
  logic [ND-1:0]   Selected;
  logic [2*ND-1:0] drive_state;

  drive_select_multi #(
    .NUM_DRIVES(ND), .SEL_WIDTH(SW), .USEC_PER_SEC(USEC),
    .SPINUP_SEC(UP), .SPINDOWN_SEC(DOWN), .SEC_W(7)
  ) dut (
    .clock(clock), .reset_L(reset_L), .clkenbl_1usec(clkenbl_1usec),
    .Cart_Ready(Cart_Ready), .BUS_FILE_READY_DRIVE_L(BUS_FILE_READY_DRIVE_L),
    .real_drive(real_drive), .drive_sel(drive_sel), .drive_sel_valid(drive_sel_valid),
    .BUS_90SEC_RELAY_EMUL_L(BUS_90SEC_RELAY_EMUL_L), .BUS_UNLOCKED_EMUL_L(BUS_UNLOCKED_EMUL_L),
    .Selected(Selected), .drive_state(drive_state)
  );

  always #5 clock = ~clock;

  // 1 us enable every 40 clocks, changed away from the active edge.
  int div = 0;
  always @(negedge clock) begin
    div = (div == 39) ? 0 : div + 1;
    clkenbl_1usec = (div == 0);
  end

  // Reference model: a phase plus the number of enables seen since entering it.
  int m_ph [ND];
  int m_en [ND];
  bit m_relay [ND];
  bit m_unl [ND];
  bit m_sel [ND];
  int en_total = 0;

  function automatic bit start_of(int i);
    return Cart_Ready[i] && !BUS_FILE_READY_DRIVE_L[i] && !real_drive[i];
  endfunction

  always @(posedge clock) begin
    if (clkenbl_1usec) en_total <= en_total + 1;
    for (int i = 0; i < ND; i++) begin
      if (!reset_L) begin
        m_ph[i] <= P_IDLE; m_en[i] <= 0;
        m_relay[i] <= 1'b1; m_unl[i] <= 1'b1; m_sel[i] <= 1'b0;
      end else begin
        m_relay[i] <= (m_ph[i] != P_READY) || real_drive[i];
        m_unl[i]   <= (m_ph[i] != P_IDLE) || real_drive[i];
        m_sel[i]   <= drive_sel_valid && (int'(drive_sel) == i) &&
                      (m_ph[i] == P_READY) && !real_drive[i];
        if (real_drive[i]) begin
          m_ph[i] <= P_IDLE; m_en[i] <= 0;
        end else if (m_ph[i] == P_IDLE) begin
          if (start_of(i)) begin m_ph[i] <= P_SPINUP; m_en[i] <= 0; end
        end else if (m_ph[i] == P_SPINUP) begin
          if (!start_of(i)) begin m_ph[i] <= P_SPINDOWN; m_en[i] <= 0; end
          else if (m_en[i] + int'(clkenbl_1usec) == UP * USEC) begin m_ph[i] <= P_READY; m_en[i] <= 0; end
          else m_en[i] <= m_en[i] + int'(clkenbl_1usec);
        end else if (m_ph[i] == P_READY) begin
          if (!start_of(i)) begin m_ph[i] <= P_SPINDOWN; m_en[i] <= 0; end
        end else begin
          if (start_of(i)) begin m_ph[i] <= P_SPINUP; m_en[i] <= 0; end
          else if (m_en[i] + int'(clkenbl_1usec) == DOWN * USEC) begin m_ph[i] <= P_IDLE; m_en[i] <= 0; end
          else m_en[i] <= m_en[i] + int'(clkenbl_1usec);
        end
      end
    end
  end

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [ND-1:0] er, eu, es;
    logic [2*ND-1:0] ed;
    for (int i = 0; i < ND; i++) begin
      er[i] = m_relay[i];
      eu[i] = m_unl[i];
      es[i] = m_sel[i];
      ed[2*i +: 2] = m_ph[i][1:0];
    end
    chk("model_relay", BUS_90SEC_RELAY_EMUL_L, er);
    chk("model_unlocked", BUS_UNLOCKED_EMUL_L, eu);
    chk("model_selected", Selected, es);
    chk("model_state", drive_state, ed);
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
    check_all();
  endtask

  task automatic wait_en(input int base, input int n, input string tag);
    int b = 0;
    while ((en_total - base) < n && b < 5000) begin
      tick();
      b++;
    end
    n_checks++;
    assert (b < 5000) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s timeout waited=%0d limit=%0d", tag, b, 5000);
    end
  endtask

  int base;

  initial begin
    // 1. Reset
    repeat (3) tick();
    chk("rst_relay", BUS_90SEC_RELAY_EMUL_L, 2'b11);
    chk("rst_unlocked", BUS_UNLOCKED_EMUL_L, 2'b11);
    chk("rst_selected", Selected, 2'b00);
    chk("rst_state", drive_state, 4'b0000);
    reset_L = 1'b1;
    tick();
    chk("rel_unlocked", BUS_UNLOCKED_EMUL_L, 2'b00);
    repeat (5) tick();

    // 2. Spin-up of drive 0
    Cart_Ready = 2'b01;
    BUS_FILE_READY_DRIVE_L = 2'b10;
    tick();
    base = en_total;
    chk("su_state", drive_state, 4'b0001);
    tick();
    chk("su_unlocked", BUS_UNLOCKED_EMUL_L, 2'b01);
    wait_en(base, UP * USEC - 1, "su_wait29");
    chk("su_state_29", drive_state[1:0], 2'd1);
    wait_en(base, UP * USEC, "su_wait30");
    chk("su_state_30", drive_state[1:0], 2'd2);
    chk("su_relay_hold", BUS_90SEC_RELAY_EMUL_L[0], 1'b1);
    tick();
    chk("su_relay", BUS_90SEC_RELAY_EMUL_L, 2'b10);
    chk("su_d1_idle", drive_state[3:2], 2'd0);
    chk("su_d1_unl", BUS_UNLOCKED_EMUL_L[1], 1'b0);

    // 3. Select decode
    drive_sel_valid = 1'b1; drive_sel = 2'd0; tick();
    chk("sel_0", Selected, 2'b01);
    drive_sel = 2'd1; tick();
    chk("sel_1", Selected, 2'b00);
    drive_sel = 2'd3; tick();
    chk("sel_3", Selected, 2'b00);
    drive_sel = 2'd0; drive_sel_valid = 1'b0; tick();
    chk("sel_invalid", Selected, 2'b00);
    for (int k = 0; k < 24; k++) begin
      drive_sel = SW'($urandom);
      drive_sel_valid = 1'($urandom);
      tick();
    end
    drive_sel_valid = 1'b0;

    // 4. Eject in READY
    Cart_Ready = 2'b00;
    tick();
    base = en_total;
    chk("ej_state", drive_state[1:0], 2'd3);
    tick();
    chk("ej_relay", BUS_90SEC_RELAY_EMUL_L[0], 1'b1);
    wait_en(base, DOWN * USEC, "ej_wait20");
    chk("ej_state_idle", drive_state[1:0], 2'd0);
    chk("ej_unl_hold", BUS_UNLOCKED_EMUL_L[0], 1'b1);
    tick();
    chk("ej_unl", BUS_UNLOCKED_EMUL_L[0], 1'b0);

    // 5. Restart partway through spin-down
    Cart_Ready = 2'b01;
    tick();
    base = en_total;
    wait_en(base, UP * USEC, "rs_spinup");
    tick();
    chk("rs_ready_relay", BUS_90SEC_RELAY_EMUL_L[0], 1'b0);
    Cart_Ready = 2'b00;
    tick();
    base = en_total;
    wait_en(base, 12, "rs_wait12");
    chk("rs_in_spindown", drive_state[1:0], 2'd3);
    Cart_Ready = 2'b01;
    tick();
    base = en_total;
    chk("rs_spinup_state", drive_state[1:0], 2'd1);
    wait_en(base, UP * USEC - 1, "rs_wait29");
    chk("rs_relay_29", BUS_90SEC_RELAY_EMUL_L[0], 1'b1);
    wait_en(base, UP * USEC, "rs_wait30");
    tick();
    chk("rs_relay_30", BUS_90SEC_RELAY_EMUL_L[0], 1'b0);

    // 6. Real drive on position 1 during its spin-up
    Cart_Ready = 2'b11;
    BUS_FILE_READY_DRIVE_L = 2'b00;
    tick();
    base = en_total;
    chk("rd_spinup", drive_state[3:2], 2'd1);
    wait_en(base, 15, "rd_wait15");
    real_drive = 2'b10;
    tick();
    chk("rd_state", drive_state[3:2], 2'd0);
    tick();
    chk("rd_relay", BUS_90SEC_RELAY_EMUL_L[1], 1'b1);
    chk("rd_unl", BUS_UNLOCKED_EMUL_L[1], 1'b1);
    drive_sel_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      drive_sel = SW'(s);
      tick();
      chk("rd_sel1", Selected[1], 1'b0);
    end
    drive_sel_valid = 1'b0;
    real_drive = 2'b00;

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 299) == 0) Cart_Ready = ND'($urandom);
      if ($urandom_range(0, 299) == 0) BUS_FILE_READY_DRIVE_L = ND'($urandom);
      if ($urandom_range(0, 999) == 0) real_drive = ND'($urandom);
      drive_sel = SW'($urandom);
      drive_sel_valid = 1'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
